// File: rtl/sprite_compositor.sv
// Three-stage sprite/background/score compositor with double-buffered registers.
// Optional macro SPRITE_HFLIP_EN enables per-sprite horizontal mirroring (ctrl bit1).
module sprite_compositor #(
  parameter int          NUM_SPRITES = 8,
  parameter int          SPRITE_DIM  = 32,
  parameter int          DIGITS      = 4,
  parameter logic [15:0] TRANSP_KEY  = 16'hF81F,
  localparam int         LOG_DIM     = $clog2(SPRITE_DIM),
  localparam int         ADDR_W      = 2*LOG_DIM+2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic [8:0]                    address,
  input  logic [31:0]                   writedata,
  input  logic [10:0]                   hcount,
  input  logic [9:0]                    vcount,
  input  logic                          blank_n_in,
  input  logic                          frame_start,
  output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
  input  logic [NUM_SPRITES*16-1:0]     rom_data,
  output logic [7:0]                    vga_r,
  output logic [7:0]                    vga_g,
  output logic [7:0]                    vga_b,
  output logic                          blank_n_out
);

  logic [9:0]          stg_x [NUM_SPRITES];
  logic [9:0]          stg_y [NUM_SPRITES];
  logic [3:0]          stg_ctrl [NUM_SPRITES];
  logic [9:0]          act_x [NUM_SPRITES];
  logic [9:0]          act_y [NUM_SPRITES];
  logic [3:0]          act_ctrl [NUM_SPRITES];
  logic [23:0]         stg_sky, stg_ground, act_sky, act_ground;
  logic [9:0]          stg_horizon, act_horizon;
  logic [4*DIGITS-1:0] stg_score, act_score;
  logic [9:0]          stg_score_x, stg_score_y, act_score_x, act_score_y;

  logic wr;
  assign wr = chipselect & write;

  // Bus writes land in staging; frame_start copies the pre-write staging into the active set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        stg_x[i] <= '0; stg_y[i] <= '0; stg_ctrl[i] <= '0;
        act_x[i] <= '0; act_y[i] <= '0; act_ctrl[i] <= '0;
      end
      stg_sky     <= 24'h87CEEB; act_sky     <= 24'h87CEEB;
      stg_ground  <= 24'h8B4513; act_ground  <= 24'h8B4513;
      stg_horizon <= 10'd200;    act_horizon <= 10'd200;
      stg_score   <= '0;         act_score   <= '0;
      stg_score_x <= '0;         act_score_x <= '0;
      stg_score_y <= '0;         act_score_y <= '0;
    end else begin
      if (wr) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (address == 9'(4*i))     stg_x[i]    <= writedata[9:0];
          if (address == 9'(4*i + 1)) stg_y[i]    <= writedata[9:0];
          if (address == 9'(4*i + 2)) stg_ctrl[i] <= writedata[3:0];
        end
        case (address)
          9'h100: stg_sky     <= writedata[23:0];
          9'h101: stg_ground  <= writedata[23:0];
          9'h102: stg_horizon <= writedata[9:0];
          9'h103: stg_score   <= writedata[4*DIGITS-1:0];
          9'h104: begin
            stg_score_x <= writedata[9:0];
            stg_score_y <= writedata[25:16];
          end
          default: ;
        endcase
      end
      if (frame_start) begin
        act_x       <= stg_x;
        act_y       <= stg_y;
        act_ctrl    <= stg_ctrl;
        act_sky     <= stg_sky;
        act_ground  <= stg_ground;
        act_horizon <= stg_horizon;
        act_score   <= stg_score;
        act_score_x <= stg_score_x;
        act_score_y <= stg_score_y;
      end
    end
  end

  function automatic logic [7:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [63:0] g;
    case (d)
      4'd0: g = 64'h3C666E7666663C00;
      4'd1: g = 64'h1838181818187E00;
      4'd2: g = 64'h3C66060C30607E00;
      4'd3: g = 64'h3C66061C06663C00;
      4'd4: g = 64'h0C1C3C6C7E0C0C00;
      4'd5: g = 64'h7E607C0606663C00;
      4'd6: g = 64'h3C607C6666663C00;
      4'd7: g = 64'h7E060C1830303000;
      4'd8: g = 64'h3C66663C66663C00;
      4'd9: g = 64'h3C66663E060C3800;
      default: g = '0;
    endcase
    return g[8*(3'd7 - r) +: 8];
  endfunction

  logic [9:0]  px;
  logic [10:0] px11, v11, sx11, sy11;
  assign px   = hcount[10:1];
  assign px11 = {1'b0, px};
  assign v11  = {1'b0, vcount};
  assign sx11 = {1'b0, act_score_x};
  assign sy11 = {1'b0, act_score_y};

  logic [NUM_SPRITES-1:0] hit_c;

  // Hit tests in 11 bits so sprites near the right/bottom edge never wrap.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    logic [10:0]         x_ext, y_ext;
    logic [LOG_DIM-1:0]  col_raw, col, row;
    logic [ADDR_W-1:0]   addr_q;
    assign x_ext    = {1'b0, act_x[i]};
    assign y_ext    = {1'b0, act_y[i]};
    assign hit_c[i] = act_ctrl[i][0] &&
                      (px11 >= x_ext) && (px11 < x_ext + 11'(SPRITE_DIM)) &&
                      (v11 >= y_ext)  && (v11 < y_ext + 11'(SPRITE_DIM));
    assign col_raw  = px[LOG_DIM-1:0] - act_x[i][LOG_DIM-1:0];
    assign row      = vcount[LOG_DIM-1:0] - act_y[i][LOG_DIM-1:0];
`ifdef SPRITE_HFLIP_EN
    assign col = act_ctrl[i][1] ? (LOG_DIM'(SPRITE_DIM-1) - col_raw) : col_raw;
`else
    logic unused_hflip;
    assign unused_hflip = act_ctrl[i][1];
    assign col = col_raw;
`endif
    always_ff @(posedge clk or posedge reset) begin
      if (reset)         addr_q <= '0;
      else if (hit_c[i]) addr_q <= {act_ctrl[i][3:2], row, col};
    end
    assign rom_addr[i*ADDR_W +: ADDR_W] = addr_q;
  end

  logic [DIGITS-1:0] digit_lit;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [10:0] ox;
    logic        in_box;
    logic [2:0]  fcol, frow;
    logic [7:0]  glyph;
    assign ox     = sx11 + 11'(10*k);
    assign in_box = (px11 >= ox) && (px11 < ox + 11'd8) &&
                    (v11 >= sy11) && (v11 < sy11 + 11'd8);
    assign fcol   = px[2:0] - ox[2:0];
    assign frow   = vcount[2:0] - act_score_y[2:0];
    assign glyph  = font_row(act_score[4*(DIGITS-1-k) +: 4], frow);
    assign digit_lit[k] = in_box && glyph[3'd7 - fcol];
  end

  logic [23:0] bg_c;
  assign bg_c = (vcount < act_horizon)  ? act_sky :
                (vcount == act_horizon) ? 24'h000000 : act_ground;

  logic [NUM_SPRITES-1:0] hit_s1, hit_s2;
  logic [23:0]            bg_s1, bg_s2;
  logic                   score_s1, score_s2, blank_s1, blank_s2;

  // Side-band data is delayed one extra stage to meet the registered ROM output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_s1 <= '0; bg_s1 <= '0; score_s1 <= 1'b0; blank_s1 <= 1'b0;
      hit_s2 <= '0; bg_s2 <= '0; score_s2 <= 1'b0; blank_s2 <= 1'b0;
    end else begin
      hit_s1   <= hit_c;
      bg_s1    <= bg_c;
      score_s1 <= |digit_lit;
      blank_s1 <= blank_n_in;
      hit_s2   <= hit_s1;
      bg_s2    <= bg_s1;
      score_s2 <= score_s1;
      blank_s2 <= blank_s1;
    end
  end

  logic        win;
  logic [15:0] win_pix;

  // Descending scan so the lowest-index opaque sprite is the last assignment.
  always_comb begin
    win     = 1'b0;
    win_pix = '0;
    for (int i = NUM_SPRITES-1; i >= 0; i--) begin
      if (hit_s2[i] && (rom_data[i*16 +: 16] != TRANSP_KEY)) begin
        win     = 1'b1;
        win_pix = rom_data[i*16 +: 16];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r <= '0; vga_g <= '0; vga_b <= '0; blank_n_out <= 1'b0;
    end else begin
      blank_n_out <= blank_s2;
      if (!blank_s2 || score_s2)
        {vga_r, vga_g, vga_b} <= 24'h000000;
      else if (win)
        {vga_r, vga_g, vga_b} <= {win_pix[15:11], 3'b000, win_pix[10:5], 2'b00, win_pix[4:0], 3'b000};
      else
        {vga_r, vga_g, vga_b} <= bg_s2;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{hcount[0], writedata};

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 8, meaning number of hardware sprite channels (1..16).
REQ-002 SHALL have parameter SPRITE_DIM, default 32, meaning sprite width and height in pixels (power of 2).
REQ-003 SHALL have parameter DIGITS, default 4, meaning number of BCD score digits drawn.
REQ-004 SHALL have parameter TRANSP_KEY, default 16'hF81F, meaning RGB565 value treated as transparent.
REQ-005 SHALL define ADDR_W = 2*log2(SPRITE_DIM)+2, meaning per-sprite ROM address width (frame select in the top 2 bits).
REQ-006 SHALL have ports, clock and reset first, as follows: reset is asynchronous, active-high; clock is clk.
REQ-007 clk  in  1  pixel-domain clock, 50 MHz.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 chipselect, write  in  1 each  bus write strobe, valid when both are high.
REQ-010 address  in  9  register index; writedata  in  32  register data.
REQ-011 hcount  in  11, vcount  in  10, blank_n_in  in  1  timing from the counter block; pixel column px = hcount[10:1].
REQ-012 frame_start  in  1  single-cycle pulse at the first blanked line after the active field.
REQ-013 rom_addr  out  NUM_SPRITES*ADDR_W  per-sprite synchronous ROM address, slice i belonging to sprite i.
REQ-014 rom_data  in  NUM_SPRITES*16  RGB565 data, valid 1 cycle after rom_addr.
REQ-015 vga_r, vga_g, vga_b  out  8 each  composed colour; blank_n_out  out  1  blank_n_in delayed to align with the colour outputs.

Function
REQ-016 Register map SHALL be as follows; writes to any other address are ignored:
- sprite i at address 4i: +0 x[9:0], +1 y[9:0], +2 ctrl (bit0 enable, bit1 hflip, bits3:2 frame).
- 0x100 sky RGB888; 0x101 ground RGB888; 0x102 horizon_y[9:0].
- 0x103 score BCD[4*DIGITS-1:0]; 0x104 score_x[9:0], score_y[25:16].
REQ-017 Bus writes SHALL update the staging copy only; the active copy SHALL load all staging registers in the cycle frame_start is high.
REQ-018 When a write and frame_start coincide, the active copy SHALL take the pre-write staging value, and the written value SHALL appear in the following frame.
REQ-019 Pipeline: S1 registers hit tests and rom_addr, S2 captures rom_data and selects the winner, S3 registers the RGB; total latency from hcount/vcount to vga_* SHALL be exactly 3 cycles.
REQ-020 Sprite i hit SHALL be: enabled, x<=px<x+SPRITE_DIM, y<=vcount<y+SPRITE_DIM, computed in 11-bit arithmetic with no wrap.
REQ-021 rom_addr SHALL be {frame, row, col}, where row=vcount-y and col=px-x (hflip: SPRITE_DIM-1-(px-x)); a non-hit sprite SHALL hold its previous address.
REQ-022 Priority: the lowest-index hit sprite whose data is not TRANSP_KEY SHALL win; each channel SHALL be expanded as R={d[15:11],000}, G={d[10:5],00}, B={d[4:0],000}.
REQ-023 Background: vcount<horizon_y gives sky, vcount==horizon_y gives 000000, vcount>horizon_y gives ground.
REQ-024 Score: digit k (k=0 most significant) SHALL be drawn in an 8x8 internal font at (score_x+10k, score_y) as 000000 lit pixels above all sprites; BCD values 10-15 SHALL draw nothing.
REQ-025 When the S3-aligned blank_n is low, vga_r, vga_g and vga_b SHALL be 0.

Reset
REQ-026 Reset SHALL clear all staging and active registers to 0 except sky=87CEEB, ground=8B4513 and horizon_y=200.
REQ-027 During and after reset, vga_*, blank_n_out and rom_addr SHALL be 0 until 3 valid cycles have passed; a mid-frame reset SHALL blank the output immediately.

Configuration
REQ-028 Macro SPRITE_HFLIP_EN: when defined, ctrl bit1 SHALL mirror columns per REQ-021; when undefined, bit1 SHALL be ignored, the hflip logic SHALL be absent, and col SHALL be px-x.

Verification
REQ-029 Sprite 0 at (100,100), enabled, ROM data 0xF800 -> hcount=200, vcount=100 gives vga=F80000 3 cycles later; hcount=264 gives the sky colour.
REQ-030 Sprites 0 and 1 overlap, sprite 0 returns F81F -> sprite 1 colour is shown; with sprite 0 returning 07E0 -> 00FC00.
REQ-031 Write x=50 mid-frame -> the sprite stays at its old x until frame_start; a write coincident with frame_start -> takes effect one frame later.
REQ-032 hflip=1, px=x -> rom_addr col=31 (with SPRITE_HFLIP_EN); without the macro -> col=0.
REQ-033 score=0x0357, score_x=225, score_y=441 -> font pixels for digits 0,3,5,7 are black at x=225/235/245/255; BCD 0xA -> blank.
REQ-034 Assert reset at vcount=300 -> vga=0 next cycle, horizon_y=200 and all sprites disabled after release.
